// File: rtl/spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: default clock dividers and
// the byte type used on the CPU-facing side.
`timescale 1ns/1ps
package spi_master_pkg;

  // Half-period of spi_clk minus one, in system clock cycles (25 MHz clk).
  localparam int unsigned SPI_DIV_FAST_DEF = 1;   // 6.25 MHz data clock
  localparam int unsigned SPI_DIV_SLOW_DEF = 31;  // 390.6 kHz SD init clock
  localparam int unsigned SPI_DIV_W_DEF    = 8;   // must hold the larger divider

  typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/spi_master_clk_div.sv
// Loadable down-counter that paces the spi_clk half-periods. It counts down
// to zero and holds there; o_tick flags the last cycle of a phase.
`timescale 1ns/1ps
module spi_clk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;

  // Reload at phase entry, otherwise count down and stop at zero (no wrap).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = (r_count == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master for the SD-card port. One byte per start
// strobe, MSB first, with a per-byte choice of slow (init) or fast clock.
`timescale 1ns/1ps
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_FAST = SPI_DIV_FAST_DEF,
  parameter int unsigned DIV_SLOW = SPI_DIV_SLOW_DEF,
  parameter int unsigned DIV_W    = SPI_DIV_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  spi_byte_t tx_byte,
  input  logic      slow,
  input  logic      cs_assert,
  output logic      busy,
  output logic      done,
  output spi_byte_t rx_byte,
  input  logic      spi_miso,
  output logic      spi_mosi,
  output logic      spi_clk,
  output logic      spi_cs
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [DIV_W-1:0] DIV_F = DIV_W'(DIV_FAST);
  localparam logic [DIV_W-1:0] DIV_S = DIV_W'(DIV_SLOW);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_shreg;     // bits still to send; bit 7 goes straight to mosi
  spi_byte_t        r_rx_shift;

  logic             w_start_ok;
  logic             w_tick;
  logic             w_load;
  logic [DIV_W-1:0] w_load_val;

  assign w_start_ok = (r_state == ST_IDLE) && start;

  // Divider reload: the freshly selected divider on start, the latched one at
  // every phase boundary.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = r_div;
    if (w_start_ok) begin
      w_load     = 1'b1;
      w_load_val = slow ? DIV_S : DIV_F;
    end else if ((r_state != ST_IDLE) && w_tick) begin
      w_load = 1'b1;
    end
  end

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_tick    (w_tick)
  );

  // Transfer FSM: IDLE -> (LOW -> HIGH) x 8 -> IDLE, miso sampled as spi_clk rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_rx_shift <= '0;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_byte    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shreg   <= tx_byte[6:0];
            r_div     <= slow ? DIV_S : DIV_F;
            r_bit_cnt <= '0;
            spi_mosi  <= tx_byte[7];
            busy      <= 1'b1;
            r_state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            spi_clk    <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], spi_miso};
            r_state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            spi_clk <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              rx_byte  <= r_rx_shift;
              done     <= 1'b1;
              busy     <= 1'b0;
              spi_mosi <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              spi_mosi  <= r_shreg[6];
              r_shreg   <= {r_shreg[5:0], 1'b0};
              r_state   <= ST_LOW;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Chip select follows cs_assert one cycle later; transfers never gate it.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_cs <= 1'b1;
    end else begin
      spi_cs <= !cs_assert;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table of single-byte transfers plus
// hand-written back-to-back, start-while-busy and reset-abort sequences.
`timescale 1ns/1ps
module tb_spi_master;
  import spi_master_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      start;
  spi_byte_t tx_byte;
  logic      slow;
  logic      cs_assert;
  logic      busy;
  logic      done;
  spi_byte_t rx_byte;
  logic      spi_miso;
  logic      spi_mosi;
  logic      spi_clk;
  logic      spi_cs;

  always #5 clk = ~clk;

  spi_master #(
    .DIV_FAST(1),
    .DIV_SLOW(31),
    .DIV_W   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_byte  (tx_byte),
    .slow     (slow),
    .cs_assert(cs_assert),
    .busy     (busy),
    .done     (done),
    .rx_byte  (rx_byte),
    .spi_miso (spi_miso),
    .spi_mosi (spi_mosi),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs)
  );

  // Free-running counters, each owned by one process.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rise_total = 0;
  always @(posedge spi_clk) rise_total <= rise_total + 1;

  // Card model: loopback, or a fixed byte presented MSB first, advancing
  // after each spi_clk rising edge.
  logic      pat_mode;
  spi_byte_t pat;
  int        rise_base;
  int        w_k;
  always_comb begin
    w_k      = rise_total - rise_base;
    spi_miso = spi_mosi;
    if (pat_mode) begin
      spi_miso = (w_k >= 0 && w_k < 8) ? pat[7 - w_k] : 1'b1;
    end
  end

  typedef struct {
    spi_byte_t rx;
    int        at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    spi_byte_t tx;
    logic      slow;
    logic      pmode;
    spi_byte_t pat;
    spi_byte_t exp_rx;
    int        exp_high;
  } vec_t;
  vec_t vecs[5];

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;
  int run = 0;
  int bad_runs = 0;
  int mosi_low = 0;
  int exp_high = 2;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock step: sample on the falling edge and run the monitors.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (spi_clk) begin
      run++;
    end else if (run != 0) begin
      if (run != exp_high) bad_runs++;
      run = 0;
    end
    if (busy && !spi_mosi) mosi_low++;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rx_byte", rx_byte, e.rx);
        chk("done_cycle", cyc, e.at);
      end
    end
  endtask

  // Drive a one-cycle start; when accepted, the result is due 16 half-periods on.
  task automatic launch(spi_byte_t tx, logic sl, spi_byte_t exp_rx, bit push);
    int half;
    half    = sl ? 32 : 2;
    tx_byte = tx;
    slow    = sl;
    start   = 1'b1;
    if (push) sb.push_back('{rx: exp_rx, at: cyc + 1 + 16 * half});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, string nm);
    int n0;
    int i;
    n0 = n_done;
    i  = 0;
    while (n_done == n0 && i < budget) begin
      tick();
      i++;
    end
    if (n_done == n0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no done within %0d cycles, expected done", nm, budget);
    end
  endtask

  initial begin
    int br0;
    int ml0;
    int n0;

    vecs[0] = '{tx: 8'hA5, slow: 1'b0, pmode: 1'b0, pat: 8'h00, exp_rx: 8'hA5, exp_high: 2};
    vecs[1] = '{tx: 8'hFF, slow: 1'b1, pmode: 1'b1, pat: 8'h3C, exp_rx: 8'h3C, exp_high: 32};
    vecs[2] = '{tx: 8'h00, slow: 1'b0, pmode: 1'b1, pat: 8'hC3, exp_rx: 8'hC3, exp_high: 2};
    vecs[3] = '{tx: 8'h3C, slow: 1'b0, pmode: 1'b0, pat: 8'h00, exp_rx: 8'h3C, exp_high: 2};
    vecs[4] = '{tx: 8'h96, slow: 1'b1, pmode: 1'b0, pat: 8'h00, exp_rx: 8'h96, exp_high: 32};

    reset     = 1'b1;
    start     = 1'b0;
    tx_byte   = 8'h00;
    slow      = 1'b0;
    cs_assert = 1'b0;
    pat_mode  = 1'b0;
    pat       = 8'h00;
    rise_base = 0;

    // Reset values after 3 cycles of reset
    repeat (3) tick();
    chk("rst_spi_cs", spi_cs, 1);
    chk("rst_spi_mosi", spi_mosi, 1);
    chk("rst_spi_clk", spi_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    reset = 1'b0;
    tick();

    // Chip select follows cs_assert one cycle later
    cs_assert = 1'b1;
    tick();
    chk("cs_low", spi_cs, 0);
    cs_assert = 1'b0;
    tick();
    chk("cs_high", spi_cs, 1);

    // Table of single transfers
    for (int i = 0; i < 5; i++) begin
      pat_mode  = vecs[i].pmode;
      pat       = vecs[i].pat;
      rise_base = rise_total;
      exp_high  = vecs[i].exp_high;
      br0       = bad_runs;
      ml0       = mosi_low;
      launch(vecs[i].tx, vecs[i].slow, vecs[i].exp_rx, 1'b1);
      chk("busy_after_start", busy, 1);
      wait_done(600, "done_timeout");
      tick();
      chk("clk_rises", rise_total - rise_base, 8);
      chk("high_len_errs", bad_runs - br0, 0);
      chk("busy_after_done", busy, 0);
      chk("mosi_idle", spi_mosi, 1);
      if (vecs[i].tx == 8'hFF) chk("mosi_high_during_ff", mosi_low - ml0, 0);
    end

    // Back-to-back: second start issued in the done cycle
    pat_mode = 1'b0;
    exp_high = 2;
    launch(8'h12, 1'b0, 8'h12, 1'b1);
    wait_done(100, "b2b_first_timeout");
    chk("b2b_done_seen", done, 1);
    launch(8'h34, 1'b0, 8'h34, 1'b1);
    chk("b2b_busy_again", busy, 1);
    wait_done(100, "b2b_second_timeout");

    // Start while busy is ignored, as are tx_byte/slow changes
    tick();
    launch(8'h81, 1'b0, 8'h81, 1'b1);
    repeat (10) tick();
    tx_byte = 8'h00;
    slow    = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    slow  = 1'b0;
    wait_done(100, "busy_start_timeout");
    n0 = n_done;
    repeat (60) tick();
    chk("single_done", n_done - n0, 0);

    // Reset mid-transfer after 3 bits
    cs_assert = 1'b1;
    launch(8'h77, 1'b0, 8'h00, 1'b0);
    repeat (13) tick();
    reset = 1'b1;
    tick();
    chk("abort_spi_clk", spi_clk, 0);
    chk("abort_spi_mosi", spi_mosi, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx_byte", rx_byte, 8'h00);
    chk("abort_spi_cs", spi_cs, 1);
    reset     = 1'b0;
    cs_assert = 1'b0;
    n0        = n_done;
    repeat (50) tick();
    chk("no_done_after_abort", n_done - n0, 0);
    launch(8'h5A, 1'b0, 8'h5A, 1'b1);
    wait_done(100, "post_abort_timeout");
    tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
